// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: IE-stage operand forwarding plus load-use, mul/div and memory-wait stall/bubble/freeze control
// Ports: id_src/id_src_vld and ie_* describe the ID and IE instructions; em_*/mw_* are the later-stage writebacks;
// mem_req/mem_ready is the data-memory handshake; fwd_sel (2 bits per operand), stall_pc, stall_ifid, bubble_ie,
// freeze_all and md_busy are the controls. Define HAZ_MULDIV_EN to build the mul/div tracker and its hazard.
module hazard_forward_ctrl #(
  parameter int RW = 5,
  parameter int NUM_SRC = 3,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_SRC*RW-1:0] id_src,
  input  logic [NUM_SRC-1:0]    id_src_vld,
  input  logic [NUM_SRC*RW-1:0] ie_src,
  input  logic [RW-1:0]         ie_rd,
  input  logic                  ie_writeback,
  input  logic                  ie_is_load,
  input  logic                  ie_is_muldiv,
  input  logic [RW-1:0]         em_rd,
  input  logic                  em_writeback,
  input  logic [RW-1:0]         mw_rd,
  input  logic                  mw_writeback,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic [NUM_SRC*2-1:0]  fwd_sel,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  bubble_ie,
  output logic                  freeze_all,
  output logic                  md_busy
);
  typedef enum logic {RUN, MEM_WAIT} state_t;
  state_t state;
  logic lu, md, freeze, stall, md_pending;
  logic [NUM_SRC*2-1:0] fwd;
  always_comb begin
    fwd = '0;
    lu = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      fwd[2*i +: 2] = (em_writeback && em_rd != '0 && em_rd == ie_src[i*RW +: RW]) ? 2'b10 :
                      (mw_writeback && mw_rd != '0 && mw_rd == ie_src[i*RW +: RW]) ? 2'b01 : 2'b00;
      lu = lu | (id_src_vld[i] && id_src[i*RW +: RW] == ie_rd);
    end
    lu = lu && ie_rd != '0 && ie_is_load && ie_writeback;
  end
  // MEM_WAIT releases in the mem_ready cycle itself, so the next state is simply "still frozen"
  assign freeze = (state == MEM_WAIT) ? !mem_ready : (mem_req && !mem_ready);
  assign stall = !freeze && (lu || md);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= RUN;
    else state <= freeze ? MEM_WAIT : RUN;
`ifdef HAZ_MULDIV_EN
  logic [3:0] md_cnt;
  logic [RW-1:0] md_rd;
  logic md_dep;
  always_comb begin
    md_dep = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) md_dep = md_dep | (id_src_vld[i] && id_src[i*RW +: RW] == md_rd);
  end
  // a second mul/div reaching IE while one is pending is a structural hazard
  assign md = md_pending && (md_dep || ie_is_muldiv);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      md_cnt <= '0;
      md_rd <= '0;
      md_pending <= 1'b0;
    end else if (ie_is_muldiv && ie_writeback && ie_rd != '0 && !freeze && !stall) begin
      md_cnt <= 4'(MULDIV_LAT);
      md_rd <= ie_rd;
      md_pending <= 1'b1;
    end else begin
      md_cnt <= md_cnt - 4'(md_cnt != '0);
      if (md_cnt == 4'd1) md_pending <= 1'b0;
    end
`else
  localparam int unused_lat = MULDIV_LAT;
  logic unused_md;
  assign unused_md = ie_is_muldiv;
  assign md = 1'b0;
  assign md_pending = 1'b0;
`endif
  assign fwd_sel = rst_n ? fwd : '0;
  assign stall_pc = rst_n && stall;
  assign stall_ifid = rst_n && stall;
  assign bubble_ie = rst_n && stall;
  assign freeze_all = rst_n && freeze;
  assign md_busy = rst_n && md_pending;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: scoreboard bench for hazard_forward_ctrl against a timestamp-based reference model
module tb_hazard_forward_ctrl;
  localparam int RW = 5;
  localparam int NS = 3;
  localparam int LAT = 4;
`ifdef HAZ_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif
  localparam int VW = NS*2 + 5;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NS*RW-1:0] id_src, ie_src;
  logic [NS-1:0] id_src_vld;
  logic [RW-1:0] ie_rd, em_rd, mw_rd;
  logic ie_writeback, ie_is_load, ie_is_muldiv, em_writeback, mw_writeback, mem_req, mem_ready;
  logic [NS*2-1:0] fwd_sel;
  logic stall_pc, stall_ifid, bubble_ie, freeze_all, md_busy;
  always #5 clk = ~clk;
  hazard_forward_ctrl #(.RW(RW), .NUM_SRC(NS), .MULDIV_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_src(id_src), .id_src_vld(id_src_vld), .ie_src(ie_src),
    .ie_rd(ie_rd), .ie_writeback(ie_writeback), .ie_is_load(ie_is_load), .ie_is_muldiv(ie_is_muldiv),
    .em_rd(em_rd), .em_writeback(em_writeback), .mw_rd(mw_rd), .mw_writeback(mw_writeback),
    .mem_req(mem_req), .mem_ready(mem_ready), .fwd_sel(fwd_sel), .stall_pc(stall_pc),
    .stall_ifid(stall_ifid), .bubble_ie(bubble_ie), .freeze_all(freeze_all), .md_busy(md_busy));
  typedef struct {
    string name;
    logic [VW-1:0] v;
  } exp_t;
  exp_t exp_q[$];
  int compared = 0;
  int mismatched = 0;
  string tag = "idle";
  bit m_wait = 1'b0;
  bit m_has = 1'b0;
  int m_issue = 0;
  int m_edge = 0;
  logic [RW-1:0] m_rd = '0;
  function automatic logic [VW-1:0] model();
    logic [NS*2-1:0] f;
    logic [RW-1:0] s;
    bit lu, dep, md, frz, stl, pend;
    if (!rst_n) return '0;
    pend = MD_EN && m_has && (m_edge - m_issue) < LAT;
    lu = 0;
    dep = 0;
    f = '0;
    for (int i = 0; i < NS; i++) begin
      s = ie_src[i*RW +: RW];
      if (em_writeback && em_rd != 0 && em_rd == s) f[2*i +: 2] = 2'b10;
      else if (mw_writeback && mw_rd != 0 && mw_rd == s) f[2*i +: 2] = 2'b01;
      s = id_src[i*RW +: RW];
      if (id_src_vld[i] && s == ie_rd) lu = 1;
      if (id_src_vld[i] && s == m_rd) dep = 1;
    end
    lu = lu && ie_rd != 0 && ie_is_load && ie_writeback;
    md = pend && (dep || ie_is_muldiv);
    frz = m_wait ? !mem_ready : (mem_req && !mem_ready);
    stl = !frz && (lu || md);
    return {f, stl, stl, stl, frz, pend};
  endfunction
  task automatic update(input logic [VW-1:0] v);
    m_edge++;
    if (!rst_n) begin
      m_wait = 0;
      m_has = 0;
    end else begin
      m_wait = v[1];
      if (MD_EN && ie_is_muldiv && ie_writeback && ie_rd != 0 && !v[1] && !v[2]) begin
        m_has = 1;
        m_issue = m_edge;
        m_rd = ie_rd;
      end
    end
  endtask
  task automatic step();
    exp_t e;
    #1;
    e.name = tag;
    e.v = model();
    exp_q.push_back(e);
    @(posedge clk);
    update(e.v);
  endtask
  task automatic clear();
    id_src = '0; ie_src = '0; id_src_vld = '0;
    ie_rd = '0; em_rd = '0; mw_rd = '0;
    ie_writeback = 0; ie_is_load = 0; ie_is_muldiv = 0;
    em_writeback = 0; mw_writeback = 0; mem_req = 0; mem_ready = 0;
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [VW-1:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {fwd_sel, stall_pc, stall_ifid, bubble_ie, freeze_all, md_busy};
      compared++;
      if (got !== e.v) begin
        mismatched++;
        $display("FAIL %s: got fwd/stall/stall/bubble/freeze/busy=%b required %b", e.name, got, e.v);
      end
    end
  end
  initial begin
    clear();
    @(posedge clk);
    tag = "reset";
    em_rd = 5; mw_rd = 5; em_writeback = 1; mw_writeback = 1; ie_src[0 +: RW] = 5;
    step();
    rst_n = 1;
    clear();
    tag = "idle";
    step();
    tag = "fwd_em_wins";
    em_rd = 5; mw_rd = 5; em_writeback = 1; mw_writeback = 1;
    ie_src[0 +: RW] = 5; ie_src[RW +: RW] = 0; ie_src[2*RW +: RW] = 5;
    step();
    tag = "fwd_mw";
    em_writeback = 0;
    step();
    tag = "fwd_r0";
    mw_rd = 0; ie_src = '0;
    step();
    clear();
    tag = "lu_stall";
    ie_is_load = 1; ie_writeback = 1; ie_rd = 7; id_src[RW +: RW] = 7; id_src_vld = 3'b010;
    step();
    tag = "lu_release";
    ie_is_load = 0; ie_writeback = 0; ie_rd = 0;
    step();
    tag = "lu_rd0";
    ie_is_load = 1; ie_writeback = 1; ie_rd = 0; id_src[RW +: RW] = 0;
    step();
    clear();
    tag = "mem_freeze";
    mem_req = 1; ie_is_load = 1; ie_writeback = 1; ie_rd = 7; id_src[RW +: RW] = 7; id_src_vld = 3'b010;
    repeat (3) step();
    tag = "mem_ready_lu";
    mem_ready = 1;
    step();
    tag = "mem_after";
    mem_req = 0; mem_ready = 0; ie_is_load = 0;
    step();
    clear();
    tag = "md_issue";
    ie_is_muldiv = 1; ie_writeback = 1; ie_rd = 9;
    step();
    tag = "md_dep";
    ie_is_muldiv = 0; ie_writeback = 0; ie_rd = 0; id_src[0 +: RW] = 9; id_src_vld = 3'b001;
    repeat (6) step();
    clear();
    tag = "md_b2b_first";
    ie_is_muldiv = 1; ie_writeback = 1; ie_rd = 9;
    step();
    tag = "md_b2b_second";
    ie_rd = 10;
    repeat (6) step();
    clear();
    tag = "md_b2b_drain";
    repeat (5) step();
    tag = "rst_setup";
    ie_is_muldiv = 1; ie_writeback = 1; ie_rd = 9;
    step();
    clear();
    mem_req = 1;
    repeat (2) step();
    tag = "async_reset";
    rst_n = 0;
    step();
    tag = "after_reset";
    rst_n = 1;
    clear();
    repeat (2) step();
    tag = "random";
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < NS; i++) begin
        id_src[i*RW +: RW] = RW'($urandom_range(0, 3));
        ie_src[i*RW +: RW] = RW'($urandom_range(0, 3));
      end
      id_src_vld = NS'($urandom);
      ie_rd = RW'($urandom_range(0, 3));
      em_rd = RW'($urandom_range(0, 3));
      mw_rd = RW'($urandom_range(0, 3));
      ie_writeback = 1'($urandom_range(0, 3) != 0);
      ie_is_load = 1'($urandom_range(0, 2) == 0);
      ie_is_muldiv = 1'($urandom_range(0, 3) == 0);
      em_writeback = 1'($urandom);
      mw_writeback = 1'($urandom);
      mem_req = 1'($urandom_range(0, 3) == 0);
      mem_ready = 1'($urandom_range(0, 2) == 0);
      rst_n = $urandom_range(0, 99) != 0;
      step();
    end
    rst_n = 1;
    clear();
    tag = "final";
    step();
    #6;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d unchecked entries required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/hazard_forward_ctrl.md
# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline (IF/ID/IE/EM/MW). It computes per-operand forwarding selects for the IE stage across `NUM_SRC` source operands. It also generates stall, bubble and freeze controls for three cases: load-use hazards, a multi-cycle mul/div unit, and a data-memory port with a ready handshake. It sits beside the ID/IE pipeline registers and drives their enables and clears.

## Interface
- `RW`, 5, register address width.
- `NUM_SRC`, 3, source operands per instruction (rs, rt, store-data).
- `MULDIV_LAT`, 4, mul/div result latency in cycles after issue; legal range 2..15.
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `id_src`  in  NUM_SRC*RW  source register addresses of the ID instruction; operand i is at [i*RW +: RW].
- `id_src_vld`  in  NUM_SRC  per-operand valid for the ID instruction.
- `ie_src`  in  NUM_SRC*RW  source register addresses of the IE instruction.
- `ie_rd`, `ie_writeback`, `ie_is_load`, `ie_is_muldiv`  in  RW,1,1,1  IE destination and type flags.
- `em_rd`, `em_writeback`  in  RW,1  EM destination and write-enable.
- `mw_rd`, `mw_writeback`  in  RW,1  MW destination and write-enable.
- `mem_req`  in  1  EM instruction is accessing data memory this cycle.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `fwd_sel`  out  NUM_SRC*2  per-operand select: 2'b10 = EM result, 2'b01 = MW result, 2'b00 = register file.
- `stall_pc`, `stall_ifid`  out  1,1  hold PC and the IF/ID register.
- `bubble_ie`  out  1  load a NOP into the ID/IE register.
- `freeze_all`  out  1  hold every pipeline register.
- `md_busy`  out  1  mul/div result pending.

## Operation
- **Forwarding.** This logic is combinational, per operand i.
  - If `em_writeback`, `em_rd`≠0 and `em_rd`==`ie_src[i]`, select 2'b10.
  - Otherwise, if the same conditions hold for MW, select 2'b01.
  - Otherwise, select 2'b00.
  - EM always wins over MW. Register 0 is never forwarded.
- **Load-use hazard (LU).** LU is asserted when:
  - some i has `id_src_vld[i]` set and `id_src[i]`==`ie_rd`, and
  - `ie_rd`≠0, `ie_is_load` and `ie_writeback` are all set.
- **Mul/div hazard (MD).** MD is asserted when `md_pending` is set and either:
  - some valid ID operand equals `md_rd`, or
  - the ID instruction is itself a mul/div. This is the structural case, signalled by `ie_is_muldiv` arriving while pending; the issue is held off by stalling ID.
- **FSM states.**
  - RUN:
    - If `mem_req` && !`mem_ready`: `freeze_all`=1 combinationally, and the next state is MEM_WAIT.
    - Otherwise, if LU or MD: `stall_pc`=`stall_ifid`=`bubble_ie`=1.
  - MEM_WAIT:
    - `freeze_all`=1 while !`mem_ready`.
    - On `mem_ready`=1, `freeze_all`=0 in that same cycle and the next state is RUN.
- **Output priority.** Freeze dominates. While `freeze_all`=1, the outputs `stall_pc`, `stall_ifid` and `bubble_ie` are 0.
- **Mul/div tracking.**
  - Issue: on an edge where `ie_is_muldiv`, `ie_writeback`, `ie_rd`≠0, `freeze_all`=0 and `bubble_ie`=0 all hold, the block loads `md_cnt`←MULDIV_LAT, `md_rd`←`ie_rd` and `md_pending`←1.
  - Countdown: `md_cnt` decrements every cycle, including during freeze.
  - Completion: on the edge where `md_cnt` goes 1→0, `md_pending`←0.
  - `md_busy` = `md_pending`.
- **Simultaneous events.**
  - A mem stall and an LU hazard in the same cycle: freeze only, and LU is re-evaluated after the freeze.
  - A mul/div completing on the same edge a new one issues: the new issue wins.

## Timing
- Forwarding selects and all stall, bubble and freeze outputs are combinational from the inputs and registered state, with zero-cycle latency.
- An LU stall lasts exactly 1 cycle unless a freeze intervenes.
- An MD stall releases in the first cycle after the 1→0 edge. After an issue at edge t, a dependent instruction is held for MULDIV_LAT cycles.
- Reset values: FSM state is RUN, `md_cnt`=0, `md_pending`=0, `md_rd`=0.
- While `rst_n`=0, every output is forced to 0, including `fwd_sel`.
- Reset asserted mid-operation clears MEM_WAIT and any pending mul/div immediately and asynchronously.

## Configuration
- `HAZ_MULDIV_EN` defined: the mul/div tracking, the MD hazard and `md_busy` are present as described above.
- `HAZ_MULDIV_EN` undefined:
  - `ie_is_muldiv` is ignored.
  - `md_pending`, `md_cnt` and `md_rd` are not built.
  - `md_busy` is tied to 0, and MD is never asserted.

## Test plan
- **Forwarding priority.** Stimulus: `em_rd`=`mw_rd`=`ie_src[0]`=5, both writebacks 1, `ie_src[1]`=0. Required: `fwd_sel[1:0]`=2'b10 and `fwd_sel[3:2]`=2'b00. Then drop `em_writeback`. Required: `fwd_sel[1:0]`=2'b01.
- **Load-use.** Stimulus: `ie_is_load`=1, `ie_rd`=7, `id_src[1]`=7 with its valid bit set. Required: `stall_pc`, `stall_ifid` and `bubble_ie` are 1 for exactly one cycle. With `ie_rd`=0, required: no stall.
- **Memory wait.** Stimulus: `mem_req`=1 with `mem_ready`=0 for 3 cycles, plus a concurrent LU. Required: `freeze_all`=1 for 3 cycles with `bubble_ie`=0. Then `mem_ready`=1. Required: the FSM returns to RUN and the LU stall asserts on the next cycle.
- **Mul/div dependency.** Stimulus: MULDIV_LAT=4, issue a mul/div to r9, then an ID instruction reads r9. Required: `md_busy`=1 and a stall for 4 cycles after the issue edge, then release with `md_busy`=0.
- **Back-to-back mul/div.** Stimulus: a second mul/div arrives while `md_pending` is set. Required: it is stalled until completion, then issues, and `md_cnt` reloads to 4.
- **Async reset.** Stimulus: assert `rst_n`=0 mid-MEM_WAIT with `md_pending`=1. Required: all outputs are 0 immediately. After release, the FSM is in RUN and `md_busy`=0.
